game_flow_ctrl: RTL and testbench

- Round/turn sequencer downstream of the projectile/health logic and upstream of the VGA overlay.
- Consumes both players' health and a "shot resolved" pulse; owns whose turn it is, a per-turn countdown, win/draw detection, and the round-restart pulse that re-arms player and projectile.
- Runs on the 50 MHz game clock.

---
 rtl/game_flow_ctrl.sv | 152 +++++++++++++++
 tb/tb_game_flow_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl
// Round/turn sequencer between the projectile/health logic and the VGA overlay.
// It starts a round on a start_btn rising edge and alternates turns on a shot
// or on a per-turn timeout. It detects a win or a draw from the two health
// values and blinks the result until the next start.
//
// Ports
//   clk          game clock, rising edge
//   rst_n        asynchronous active-low reset
//   start_btn    debounced start/restart level (rising edge detected here)
//   shot_done    one-cycle pulse: projectile hit or left the field
//   health_0/1   player health, 0 = dead
//   round_reset  one-cycle pulse re-arming player and projectile state
//   game_active  high only while a round is being played
//   turn         0 = player 0 to move, 1 = player 1
//   turn_switch  one-cycle pulse on every turn change
//   secs_left    remaining seconds in the current turn
//   winner       00 none, 01 player 0 won, 10 player 1 won, 11 draw
//   blink        toggles every tick once the round is over
//
// state | meaning
// IDLE  | after reset, waiting for a start edge
// SERVE | one cycle: round_reset pulse, round state re-initialised
// PLAY  | turns running, countdown active, health watched after grace
// OVER  | result held, blink running, waiting for a start edge
module game_flow_ctrl #(
    parameter int TICK_DIV  = 50000000,
    parameter int TURN_SECS = 15,
    parameter int GRACE     = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_btn,
    input  logic       shot_done,
    input  logic [2:0] health_0,
    input  logic [2:0] health_1,
    output logic       round_reset,
    output logic       game_active,
    output logic       turn,
    output logic       turn_switch,
    output logic [4:0] secs_left,
    output logic [1:0] winner,
    output logic       blink
);

    typedef enum logic [1:0] {IDLE, SERVE, PLAY, OVER} state_t;

    localparam logic [4:0]  SECS_INIT = 5'(TURN_SECS);
    localparam logic [25:0] TICK_LAST = 26'(TICK_DIV - 1);
    localparam int          GW        = (GRACE < 1) ? 1 : $clog2(GRACE + 1);
    localparam logic [GW-1:0] GRACE_END = GW'(GRACE);

    state_t        state;
    logic          start_btn_q;
    logic          armed;
    logic [25:0]   tick_cnt;
    logic [GW-1:0] grace_cnt;

    logic start_edge;
    logic tick_run;
    logic tick;
    logic grace_done;
    logic p0_dead;
    logic p1_dead;
    logic turn_change;
    logic go_serve;

    // A button held high through reset must be seen low once before its
    // next rising edge counts, so a held button cannot start a round.
    assign start_edge  = start_btn & ~start_btn_q & armed;
    assign tick_run    = (state == PLAY) || (state == OVER);
    assign tick        = tick_run && (tick_cnt == TICK_LAST);
    assign grace_done  = (grace_cnt == GRACE_END);
    assign p0_dead     = (health_0 == 3'd0);
    assign p1_dead     = (health_1 == 3'd0);
    assign turn_change = shot_done || (tick && (secs_left == 5'd1));
    assign go_serve    = start_edge && ((state == IDLE) || (state == OVER));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            start_btn_q <= 1'b0;
            armed       <= 1'b0;
            tick_cnt    <= '0;
            grace_cnt   <= '0;
            round_reset <= 1'b0;
            game_active <= 1'b0;
            turn        <= 1'b0;
            turn_switch <= 1'b0;
            secs_left   <= SECS_INIT;
            winner      <= 2'b00;
            blink       <= 1'b0;
        end else begin
            start_btn_q <= start_btn;
            if (!start_btn) begin
                armed <= 1'b1;
            end
            round_reset <= 1'b0;
            turn_switch <= 1'b0;

            if (tick_run) begin
                tick_cnt <= tick ? '0 : tick_cnt + 26'd1;
            end else begin
                tick_cnt <= '0;
            end

            case (state)
                IDLE: ;
                SERVE: begin
                    state       <= PLAY;
                    game_active <= 1'b1;
                    tick_cnt    <= '0;
                    grace_cnt   <= '0;
                end
                PLAY: begin
                    if (!grace_done) begin
                        grace_cnt <= grace_cnt + 1'b1;
                    end
                    // A death outranks any turn change in the same cycle.
                    if (grace_done && (p0_dead || p1_dead)) begin
                        state       <= OVER;
                        game_active <= 1'b0;
                        winner      <= {p0_dead, p1_dead};
                    end else if (turn_change) begin
                        turn        <= ~turn;
                        turn_switch <= 1'b1;
                        secs_left   <= SECS_INIT;
                        tick_cnt    <= '0;
                    end else if (tick) begin
                        secs_left <= secs_left - 5'd1;
                    end
                end
                OVER: begin
                    if (tick) begin
                        blink <= ~blink;
                    end
                end
                default: state <= IDLE;
            endcase

            if (go_serve) begin
                state       <= SERVE;
                round_reset <= 1'b1;
                turn        <= 1'b0;
                secs_left   <= SECS_INIT;
                winner      <= 2'b00;
                blink       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
module tb_game_flow_ctrl;

    localparam int TD = 4;
    localparam int TS = 3;
    localparam int GR = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start_btn = 1'b0;
    logic       shot_done = 1'b0;
    logic [2:0] health_0 = 3'd3;
    logic [2:0] health_1 = 3'd3;
    logic       round_reset, game_active, turn, turn_switch, blink;
    logic [4:0] secs_left;
    logic [1:0] winner;

    game_flow_ctrl #(.TICK_DIV(TD), .TURN_SECS(TS), .GRACE(GR)) dut (
        .clk(clk), .rst_n(rst_n), .start_btn(start_btn), .shot_done(shot_done),
        .health_0(health_0), .health_1(health_1),
        .round_reset(round_reset), .game_active(game_active), .turn(turn),
        .turn_switch(turn_switch), .secs_left(secs_left), .winner(winner),
        .blink(blink)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rr;
        logic       ga;
        logic       turn;
        logic       ts;
        logic [4:0] secs;
        logic [1:0] win;
        logic       blink;
    } out_t;

    out_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // Reference model: phase 0 waiting, 1 serve, 2 playing, 3 result shown.
    int m_phase, m_prev_btn, m_seen_low, m_tcnt, m_play_cyc;
    int m_rr, m_ga, m_turn, m_ts, m_secs, m_win, m_blink;

    function automatic void model_reset();
        m_phase = 0; m_prev_btn = 0; m_seen_low = 0; m_tcnt = 0; m_play_cyc = 0;
        m_rr = 0; m_ga = 0; m_turn = 0; m_ts = 0; m_secs = TS; m_win = 0; m_blink = 0;
    endfunction

    function automatic void model_step(input int rst, input int btn, input int shot,
                                       input int h0, input int h1);
        int edge_s, running, tk;
        if (rst == 0) begin
            model_reset();
            return;
        end
        edge_s = (btn != 0 && m_prev_btn == 0 && m_seen_low != 0) ? 1 : 0;
        if (btn == 0) m_seen_low = 1;
        m_prev_btn = btn;
        running = (m_phase == 2 || m_phase == 3) ? 1 : 0;
        tk = (running != 0 && (m_tcnt % TD) == TD - 1) ? 1 : 0;
        m_tcnt = (running != 0) ? m_tcnt + 1 : 0;
        m_rr = 0;
        m_ts = 0;
        case (m_phase)
            1: begin
                m_phase = 2; m_ga = 1; m_tcnt = 0; m_play_cyc = 0;
            end
            2: begin
                int watch;
                watch = (m_play_cyc >= GR) ? 1 : 0;
                m_play_cyc++;
                if (watch != 0 && (h0 == 0 || h1 == 0)) begin
                    m_phase = 3; m_ga = 0;
                    m_win = ((h0 == 0) ? 2 : 0) + ((h1 == 0) ? 1 : 0);
                end else if (shot != 0 || (tk != 0 && m_secs == 1)) begin
                    m_turn = 1 - m_turn; m_ts = 1; m_secs = TS; m_tcnt = 0;
                end else if (tk != 0) begin
                    m_secs--;
                end
            end
            3: if (tk != 0) m_blink = 1 - m_blink;
            default: ;
        endcase
        if (edge_s != 0 && (m_phase == 0 || m_phase == 3)) begin
            m_phase = 1; m_rr = 1; m_turn = 0; m_secs = TS; m_win = 0; m_blink = 0;
        end
    endfunction

    // One cycle of stimulus: inputs applied at the negedge, expectation for
    // the state after the following posedge queued for the monitor.
    task automatic drive(input int rst, input int btn, input int shot,
                         input int h0, input int h1);
        out_t e;
        @(negedge clk);
        rst_n = rst[0];
        start_btn = btn[0];
        shot_done = shot[0];
        health_0 = 3'(h0);
        health_1 = 3'(h1);
        model_step(rst, btn, shot, h0, h1);
        e.rr = m_rr[0]; e.ga = m_ga[0]; e.turn = m_turn[0]; e.ts = m_ts[0];
        e.secs = 5'(m_secs); e.win = 2'(m_win); e.blink = m_blink[0];
        exp_q.push_back(e);
    endtask

    task automatic idle_n(input int n, input int btn);
        for (int i = 0; i < n; i++) drive(1, btn, 0, 3, 3);
    endtask

    // Monitor: compares every presented output cycle against the scoreboard.
    initial begin
        out_t e, a;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{round_reset, game_active, turn, turn_switch, secs_left, winner, blink};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs cycle %0d: got rr=%b ga=%b turn=%b ts=%b secs=%0d win=%b blink=%b, expected rr=%b ga=%b turn=%b ts=%b secs=%0d win=%b blink=%b",
                             cyc, a.rr, a.ga, a.turn, a.ts, a.secs, a.win, a.blink,
                             e.rr, e.ga, e.turn, e.ts, e.secs, e.win, e.blink);
                end
            end
        end
    end

    initial begin
        int done;
        model_reset();
        // Reset, then start a round.
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 3, 3);
        idle_n(2, 0);
        idle_n(1, 1);
        // Hold PLAY with no shots through a full timeout and beyond.
        idle_n(18, 1);
        // Shot while two seconds remain.
        done = 0;
        for (int i = 0; i < 40 && done == 0; i++) begin
            if (m_phase == 2 && m_secs == 2) begin
                drive(1, 1, 1, 3, 3); done = 1;
            end else drive(1, 1, 0, 3, 3);
        end
        idle_n(6, 1);
        // Shot coinciding with the timeout tick.
        done = 0;
        for (int i = 0; i < 40 && done == 0; i++) begin
            if (m_phase == 2 && m_secs == 1 && (m_tcnt % TD) == TD - 1) begin
                drive(1, 1, 1, 3, 3); done = 1;
            end else drive(1, 1, 0, 3, 3);
        end
        idle_n(6, 1);
        // Player 1 dies together with a shot.
        drive(1, 1, 1, 3, 0);
        idle_n(13, 1);
        // Restart from OVER; health zero during SERVE and the first two PLAY cycles.
        idle_n(2, 0);
        drive(1, 1, 0, 3, 3);
        drive(1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        idle_n(8, 1);
        // Both players die: draw.
        drive(1, 1, 0, 0, 0);
        idle_n(6, 1);
        // New round, then reset mid-PLAY with the button held.
        idle_n(1, 0);
        idle_n(6, 1);
        drive(0, 1, 0, 3, 3);
        drive(0, 1, 0, 3, 3);
        idle_n(6, 1);
        idle_n(2, 0);
        idle_n(6, 1);
        // Randomised play.
        for (int i = 0; i < 1500; i++) begin
            int r, b, s, h0, h1;
            r = ($urandom_range(0, 299) == 0) ? 0 : 1;
            b = ($urandom_range(0, 19) == 0) ? 1 - m_prev_btn : m_prev_btn;
            s = ($urandom_range(0, 7) == 0) ? 1 : 0;
            h0 = ($urandom_range(0, 39) == 0) ? 0 : int'($urandom_range(1, 7));
            h1 = ($urandom_range(0, 39) == 0) ? 0 : int'($urandom_range(1, 7));
            drive(r, b, s, h0, h1);
        end
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
